// File: rtl/lock_controller_if.sv
// Key-entry and status bundle between the debounced front end, the lock
// controller and the display logic.
interface lock_controller_if #(
  parameter int CODE_LEN  = 6,
  parameter int MAX_FAILS = 3
);
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  logic              digit_valid;
  logic [3:0]        digit;
  logic              relock;
  logic              prog_req;
  logic              unlocked;
  logic              locked_out;
  logic              prog_mode;
  logic              fail_pulse;
  logic [FAIL_W-1:0] fail_count;
  logic [CNT_W-1:0]  digit_count;

  modport master (
    output digit_valid, digit, relock, prog_req,
    input  unlocked, locked_out, prog_mode, fail_pulse, fail_count, digit_count
  );

  modport slave (
    input  digit_valid, digit, relock, prog_req,
    output unlocked, locked_out, prog_mode, fail_pulse, fail_count, digit_count
  );
endinterface

// File: rtl/lock_controller.sv
// Combination-lock sequencer: digit entry against a programmable code,
// failed-attempt lockout, and code reprogramming while open.
module lock_controller #(
  parameter int                        CODE_LEN       = 6,
  parameter int                        MAX_FAILS      = 3,
  parameter int                        LOCKOUT_CYCLES = 16,
  parameter logic [4*CODE_LEN-1:0]     DEFAULT_CODE   = 24'h320474
) (
  input logic               clk,
  input logic               rst_n,
  lock_controller_if.slave  bus
);
  localparam int CODE_W = 4 * CODE_LEN;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;
  localparam logic [1:0] ST_PROGRAM = 2'd3;

  logic [1:0]        state;
  logic [CODE_W-1:0] code_reg;
  logic [CODE_W-1:0] shadow;
  logic [CODE_W-1:0] shifted;
  logic              mismatch;
  logic [LOCK_W-1:0] lock_cnt;
  logic [CNT_W-1:0]  digit_count;
  logic [FAIL_W-1:0] fail_count;
  logic              unlocked;
  logic              locked_out;
  logic              prog_mode;
  logic              fail_pulse;
  logic              digit_ok;
  logic              digit_bad;
  logic              mis_next;
  logic              last_digit;
  logic [FAIL_W-1:0] fail_inc;

  function automatic logic [3:0] nibble_at(input logic [CODE_W-1:0] code,
                                           input logic [CNT_W-1:0]  idx);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < CODE_LEN; i++)
      if (idx == CNT_W'(i)) n = code[4*(CODE_LEN-1-i) +: 4];
    return n;
  endfunction

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] fc);
    if (fc == FAIL_W'(MAX_FAILS)) return fc;
    return fc + 1'b1;
  endfunction

  always_comb begin
    digit_ok   = (bus.digit <= 4'd9);
    digit_bad  = !digit_ok || (bus.digit != nibble_at(code_reg, digit_count));
    mis_next   = mismatch || digit_bad;
    last_digit = (digit_count == CNT_W'(CODE_LEN - 1));
    fail_inc   = sat_inc(fail_count);
    shifted    = (shadow << 4) | {{(CODE_W-4){1'b0}}, bus.digit};
  end

  // Shadow only holds data in PROGRAM; its contents are meaningless elsewhere.
  always_ff @(posedge clk) begin
    if (state == ST_PROGRAM && bus.digit_valid && digit_ok && !bus.relock)
      shadow <= shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ENTRY;
      code_reg    <= DEFAULT_CODE;
      mismatch    <= 1'b0;
      lock_cnt    <= '0;
      digit_count <= '0;
      fail_count  <= '0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      prog_mode   <= 1'b0;
      fail_pulse  <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (bus.digit_valid) begin
            if (last_digit) begin
              digit_count <= '0;
              mismatch    <= 1'b0;
              if (!mis_next) begin
                state      <= ST_OPEN;
                unlocked   <= 1'b1;
                fail_count <= '0;
              end else begin
                fail_pulse <= 1'b1;
                fail_count <= fail_inc;
                if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                  state      <= ST_LOCKOUT;
                  locked_out <= 1'b1;
                  lock_cnt   <= LOCK_W'(LOCKOUT_CYCLES);
                end
              end
            end else begin
              digit_count <= digit_count + 1'b1;
              mismatch    <= mis_next;
            end
          end
        end
        ST_LOCKOUT: begin
          lock_cnt <= lock_cnt - 1'b1;
          if (lock_cnt == LOCK_W'(1)) begin
            state      <= ST_ENTRY;
            locked_out <= 1'b0;
            fail_count <= '0;
          end
        end
        ST_OPEN: begin
          if (bus.relock) begin
            state    <= ST_ENTRY;
            unlocked <= 1'b0;
          end else if (bus.prog_req) begin
            state       <= ST_PROGRAM;
            unlocked    <= 1'b0;
            prog_mode   <= 1'b1;
            digit_count <= '0;
          end
        end
        default: begin
          // Abort takes priority, including over a coincident final digit.
          if (bus.relock) begin
            state       <= ST_ENTRY;
            prog_mode   <= 1'b0;
            digit_count <= '0;
          end else if (bus.digit_valid && digit_ok) begin
            if (last_digit) begin
              code_reg    <= shifted;
              digit_count <= '0;
              state       <= ST_ENTRY;
              prog_mode   <= 1'b0;
            end else begin
              digit_count <= digit_count + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.unlocked    = unlocked;
  assign bus.locked_out  = locked_out;
  assign bus.prog_mode   = prog_mode;
  assign bus.fail_pulse  = fail_pulse;
  assign bus.fail_count  = fail_count;
  assign bus.digit_count = digit_count;
endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller: vector table for entry/failure flow,
// hand sequences for lockout, programming, abort and async reset.
module tb_lock_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lock_controller_if #(.CODE_LEN(6), .MAX_FAILS(3)) bus ();

  lock_controller #(
    .CODE_LEN(6), .MAX_FAILS(3), .LOCKOUT_CYCLES(16), .DEFAULT_CODE(24'h320474)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       rl;
    logic       pr;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  // Packed status: {unlocked, locked_out, prog_mode, fail_pulse, fail_count[1:0], digit_count[2:0]}
  function automatic logic [8:0] ex(int un, int lo, int pm, int fp, int fc, int dc);
    return {1'(un), 1'(lo), 1'(pm), 1'(fp), 2'(fc), 3'(dc)};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.unlocked, bus.locked_out, bus.prog_mode, bus.fail_pulse,
            bus.fail_count, bus.digit_count};
  endfunction

  function automatic vec_t mk(int v, int d, int rl, int pr, logic [8:0] e);
    vec_t r;
    r.v = 1'(v); r.d = 4'(d); r.rl = 1'(rl); r.pr = 1'(pr); r.exp = e;
    return r;
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got {un,lo,pm,fp,fc,dc}=%b required %b", name, act, exp);
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic cyc(logic v, logic [3:0] d, logic rl, logic pr);
    @(negedge clk);
    bus.digit_valid = v; bus.digit = d; bus.relock = rl; bus.prog_req = pr;
    @(posedge clk);
    #1;
    bus.digit_valid = 1'b0; bus.digit = 4'd0; bus.relock = 1'b0; bus.prog_req = 1'b0;
  endtask

  task automatic attempt(logic [23:0] code);
    for (int i = 0; i < 6; i++) cyc(1'b1, code[4*(5-i) +: 4], 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    logic [3:0] pdig [6];
    int         pdc  [6];

    rst_n = 1'b0;
    bus.digit_valid = 1'b0; bus.digit = 4'd0; bus.relock = 1'b0; bus.prog_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", outs(), ex(0,0,0,0,0,0));
    @(negedge clk) rst_n = 1'b1;

    // Correct code with a strobe every other cycle
    vecs.push_back(mk(0,0,0,0, ex(0,0,0,0,0,0)));
    vecs.push_back(mk(1,3,0,0, ex(0,0,0,0,0,1)));
    vecs.push_back(mk(0,0,0,0, ex(0,0,0,0,0,1)));
    vecs.push_back(mk(1,2,0,0, ex(0,0,0,0,0,2)));
    vecs.push_back(mk(0,0,0,0, ex(0,0,0,0,0,2)));
    vecs.push_back(mk(1,0,0,0, ex(0,0,0,0,0,3)));
    vecs.push_back(mk(0,0,0,0, ex(0,0,0,0,0,3)));
    vecs.push_back(mk(1,4,0,0, ex(0,0,0,0,0,4)));
    vecs.push_back(mk(0,0,0,0, ex(0,0,0,0,0,4)));
    vecs.push_back(mk(1,7,0,0, ex(0,0,0,0,0,5)));
    vecs.push_back(mk(0,0,0,0, ex(0,0,0,0,0,5)));
    vecs.push_back(mk(1,4,0,0, ex(1,0,0,0,0,0)));
    vecs.push_back(mk(0,0,0,0, ex(1,0,0,0,0,0)));
    vecs.push_back(mk(1,5,0,0, ex(1,0,0,0,0,0)));
    vecs.push_back(mk(0,0,1,1, ex(0,0,0,0,0,0)));
    vecs.push_back(mk(0,0,0,0, ex(0,0,0,0,0,0)));
    // First failure: last digit wrong
    vecs.push_back(mk(1,3,0,0, ex(0,0,0,0,0,1)));
    vecs.push_back(mk(1,2,0,0, ex(0,0,0,0,0,2)));
    vecs.push_back(mk(1,0,0,0, ex(0,0,0,0,0,3)));
    vecs.push_back(mk(1,4,0,0, ex(0,0,0,0,0,4)));
    vecs.push_back(mk(1,7,0,0, ex(0,0,0,0,0,5)));
    vecs.push_back(mk(1,5,0,0, ex(0,0,0,1,1,0)));
    vecs.push_back(mk(0,0,0,0, ex(0,0,0,0,1,0)));
    // Second failure: invalid digit counted, no early reject
    vecs.push_back(mk(1,3,0,0,  ex(0,0,0,0,1,1)));
    vecs.push_back(mk(1,2,0,0,  ex(0,0,0,0,1,2)));
    vecs.push_back(mk(1,11,0,0, ex(0,0,0,0,1,3)));
    vecs.push_back(mk(1,4,0,0,  ex(0,0,0,0,1,4)));
    vecs.push_back(mk(1,7,0,0,  ex(0,0,0,0,1,5)));
    vecs.push_back(mk(1,4,0,0,  ex(0,0,0,1,2,0)));
    vecs.push_back(mk(0,0,0,0,  ex(0,0,0,0,2,0)));
    // Third failure enters lockout
    vecs.push_back(mk(1,3,0,0, ex(0,0,0,0,2,1)));
    vecs.push_back(mk(1,2,0,0, ex(0,0,0,0,2,2)));
    vecs.push_back(mk(1,0,0,0, ex(0,0,0,0,2,3)));
    vecs.push_back(mk(1,4,0,0, ex(0,0,0,0,2,4)));
    vecs.push_back(mk(1,7,0,0, ex(0,0,0,0,2,5)));
    vecs.push_back(mk(1,5,0,0, ex(0,1,0,1,3,0)));

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].rl, vecs[i].pr);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Lockout with the correct code, relock and prog_req injected
    n = 1;
    pdig[0] = 4'd3; pdig[1] = 4'd2; pdig[2] = 4'd0;
    pdig[3] = 4'd4; pdig[4] = 4'd7; pdig[5] = 4'd4;
    for (int k = 0; k < 40; k++) begin
      cyc((k % 2 == 0) && (k < 12), pdig[(k/2) % 6], k == 1, k == 3);
      if (!bus.locked_out) break;
      n++;
      check($sformatf("lockout_k%0d", k), outs(), ex(0,1,0,0,3,0));
    end
    check_int("lockout_len", n, 16);
    check("after_lockout", outs(), ex(0,0,0,0,0,0));
    attempt(24'h320474);
    check("unlock_after_lockout", outs(), ex(1,0,0,0,0,0));

    // Reprogram to 123456; 0xC ignored
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    check("enter_program", outs(), ex(0,0,1,0,0,0));
    pdig[0] = 4'd1; pdig[1] = 4'hC; pdig[2] = 4'd2;
    pdig[3] = 4'd3; pdig[4] = 4'd4; pdig[5] = 4'd5;
    pdc[0] = 1; pdc[1] = 1; pdc[2] = 2; pdc[3] = 3; pdc[4] = 4; pdc[5] = 5;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, pdig[i], 1'b0, 1'b0);
      check($sformatf("prog_d%0d", i), outs(), ex(0,0,1,0,0,pdc[i]));
    end
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    check("prog_commit", outs(), ex(0,0,0,0,0,0));
    attempt(24'h320474);
    check("old_code_fails", outs(), ex(0,0,0,1,1,0));
    attempt(24'h123456);
    check("new_code_unlocks", outs(), ex(1,0,0,0,0,0));

    // Async reset in the middle of lockout
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    attempt(24'h000000);
    attempt(24'h000000);
    attempt(24'h000000);
    check("lockout_again", outs(), ex(0,1,0,1,3,0));
    repeat (4) cyc(1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), ex(0,0,0,0,0,0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    attempt(24'h123456);
    check("code_reverted_fail", outs(), ex(0,0,0,1,1,0));
    attempt(24'h320474);
    check("default_unlocks", outs(), ex(1,0,0,0,0,0));

    // Abort with relock coincident with the final digit
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    check("enter_program2", outs(), ex(0,0,1,0,0,0));
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'(6 - i), 1'b0, 1'b0);
    check("prog2_5digits", outs(), ex(0,0,1,0,0,5));
    cyc(1'b1, 4'd1, 1'b1, 1'b0);
    check("abort_final", outs(), ex(0,0,0,0,0,0));
    attempt(24'h654321);
    check("aborted_code_fails", outs(), ex(0,0,0,1,1,0));
    attempt(24'h320474);
    check("code_kept", outs(), ex(1,0,0,0,0,0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/lock_controller.md
Name: lock_controller

Overview:
- Sequencing and configuration controller for the board's combination-lock resource.
- Collects a stream of BCD digit strobes and compares them against a programmable code register.
- Enforces a failed-attempt lockout window.
- While open, allows the code to be reprogrammed. Sits between the debounced key/switch front end and the HEX/LED display logic.

Parameters:
- CODE_LEN, 6, number of digits per attempt and per programmed code (2..8).
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout (>=1).
- DEFAULT_CODE, 24'h320474, reset code. First digit is in the most-significant nibble; width is 4*CODE_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- digit_valid  in  1  one-cycle strobe; digit is sampled on this cycle.
- digit  in  4  entered digit, BCD; values 10..15 are invalid.
- relock  in  1  strobe: leave OPEN or abort PROGRAM.
- prog_req  in  1  strobe: enter PROGRAM from OPEN.
- unlocked  out  1  high in OPEN.
- locked_out  out  1  high in LOCKOUT.
- prog_mode  out  1  high in PROGRAM.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures.
- digit_count  out  $clog2(CODE_LEN+1)  digits accepted in the current attempt or program sequence.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=ENTRY; code register=DEFAULT_CODE.
  - All outputs 0; mismatch flag 0; lockout counter 0.
- All outputs are registered, with no combinational input-to-output path.
- States: ENTRY, OPEN, LOCKOUT, PROGRAM.
- ENTRY:
  - Each digit_valid increments digit_count.
  - The mismatch flag is set if the digit is invalid (>9) or differs from the code nibble at index digit_count.
  - There is no early reject: exactly CODE_LEN digits are always consumed.
  - On the edge sampling digit CODE_LEN, digit_count is cleared and the result is evaluated from the flag including this digit:
    - Match: next state OPEN, fail_count cleared. unlocked is high from the following cycle.
    - Mismatch: fail_pulse high for exactly one cycle and fail_count increments.
    - Mismatch with new count == MAX_FAILS: next state LOCKOUT, counter loaded with LOCKOUT_CYCLES.
    - Mismatch otherwise: stay in ENTRY.
  - The mismatch flag clears after every evaluation.
  - relock and prog_req are ignored in ENTRY.
- LOCKOUT:
  - digit_valid, relock and prog_req are ignored; digit_count holds 0.
  - The counter decrements every cycle. On the cycle it equals 1, the next state is ENTRY and fail_count clears.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
- OPEN:
  - digit_valid is ignored.
  - relock: next state ENTRY.
  - prog_req (without relock): next state PROGRAM, digit_count cleared.
  - relock and prog_req together: relock wins.
- PROGRAM:
  - A valid digit (<=9) shifts into a shadow register and increments digit_count. Invalid digits are ignored and not counted.
  - On the CODE_LEN-th valid digit:
    - Shadow plus the final digit commit to the code register (first-entered digit in the MSB nibble).
    - digit_count clears; next state ENTRY (locked).
  - relock at any point aborts: code unchanged, shadow discarded, next state ENTRY.
  - relock coincident with the final digit: abort wins, no commit.
- fail_count saturates at MAX_FAILS and never wraps.
- Reset asserted mid-attempt, mid-lockout or mid-program returns to the reset state immediately. A programmed code reverts to DEFAULT_CODE.
- No timeout on partial entry: a partial attempt persists until completed or reset.

Test Plan:
- Reset, then digits 3,2,0,4,7,4 with one strobe every 2 cycles -> unlocked=1 on the cycle after the 6th strobe's edge; fail_count=0; fail_pulse never high.
- Attempts 3,2,0,4,7,5 three times -> fail_pulse once per attempt; fail_count 1, 2, 3. On the third, locked_out=1 for exactly 16 cycles, then fail_count=0 and state ENTRY.
- During lockout, send 6 digit strobes plus relock and prog_req -> digit_count stays 0, lockout length unchanged. After lockout, the correct code unlocks.
- Digits 3,2,0xB,4,7,4 -> treated as a failure (fail_count=1); digit_count reaches 6 then 0.
- Open, then prog_req, then digits 1,0xC,2,3,4,5,6 -> 0xC ignored; commit code 0x123456; unlocked=0, prog_mode=0. Old code then fails (fail_count=1); 1,2,3,4,5,6 unlocks.
- Open, then relock and prog_req in the same cycle -> state ENTRY, prog_mode stays 0.
- In PROGRAM, relock together with the 6th digit -> code remains 0x320474.
- rst_n low mid-lockout -> all outputs 0 asynchronously, code=DEFAULT_CODE.
